// File: rtl/envelope_follower_pkg.sv
// Shared synth definitions: envelope FSM encoding and the offset-binary
// midscale used by both the envelope follower and the amplitude modulator.
package envelope_follower_pkg;

   typedef enum logic [1:0] {
      ENV_IDLE    = 2'd0,
      ENV_ATTACK  = 2'd1,
      ENV_HOLD    = 2'd2,
      ENV_RELEASE = 2'd3
   } env_state_e;

   localparam int unsigned OB_DEFAULT_BITS = 12;

   // Offset-binary silence level for a sample of the given width.
   function automatic int unsigned ob_midscale(input int unsigned data_bits);
      return 32'd1 << (data_bits - 1);
   endfunction

   localparam int unsigned OB_MIDSCALE = ob_midscale(OB_DEFAULT_BITS);

endpackage

// File: rtl/envelope_follower_offset_to_magnitude.sv
// Stage 1 of the envelope follower: offset-binary sample to unsigned
// magnitude (most-negative code saturates) plus full-scale clip detect.
module offset_to_magnitude
   import envelope_follower_pkg::*;
#(
   parameter int DATA_BITS = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_valid,
   input  logic [DATA_BITS-1:0] din,
   output logic                 mag_valid,
   output logic [DATA_BITS-2:0] mag,
   output logic                 clip
);

   localparam logic [DATA_BITS-1:0] MIDSCALE = DATA_BITS'(ob_midscale(DATA_BITS));

   logic [DATA_BITS-1:0] s;
   logic [DATA_BITS-1:0] s_abs;
   logic [DATA_BITS-2:0] mag_d;
   logic                 clip_d;

   // Two's-complement view, absolute value, saturate the lone code with no positive twin.
   always_comb begin
      s      = din ^ MIDSCALE;
      s_abs  = s[DATA_BITS-1] ? ((~s) + DATA_BITS'(1)) : s;
      mag_d  = s_abs[DATA_BITS-1] ? '1 : s_abs[DATA_BITS-2:0];
      clip_d = (din == '0) || (din == '1);
   end

   // Stage-1 register; magnitude and clip only move on a qualified sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_valid <= 1'b0;
         mag       <= '0;
         clip      <= 1'b0;
      end else begin
         mag_valid <= sample_valid;
         if (sample_valid) begin
            mag  <= mag_d;
            clip <= clip_d;
         end
      end
   end

endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: peak detector with attack smoothing, sample-counted
// hold and exponential release. Two-cycle latency, one sample per cycle.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ENV_IDLE    | env is 0, input silent
// ENV_ATTACK  | env rising toward the latest magnitude
// ENV_HOLD    | peak held, hold_cnt counting samples down
// ENV_RELEASE | env decaying by max(1, env >> RELEASE_SHIFT) per sample
module envelope_follower
   import envelope_follower_pkg::*;
#(
   parameter int DATA_BITS      = 12,
   parameter int AMPLITUDE_BITS = 8,
   parameter int ATTACK_SHIFT   = 0,
   parameter int RELEASE_SHIFT  = 4,
   parameter int HOLD_SAMPLES   = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sample_valid,
   input  logic [DATA_BITS-1:0]      din,
   output logic [AMPLITUDE_BITS-1:0] amplitude,
   output logic                      amplitude_valid,
   output logic                      clip,
   output logic [1:0]                state
);

   localparam int EW = DATA_BITS - 1;

   env_state_e    st_q, st_d;
   logic [EW-1:0] env_q, env_d;
   logic [EW-1:0] att_step, rel_step;
   logic [15:0]   hold_q, hold_d;

   logic          s1_valid;
   logic [EW-1:0] s1_mag;
   logic          s1_clip;

   offset_to_magnitude #(
      .DATA_BITS (DATA_BITS)
   ) u_mag (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .din          (din),
      .mag_valid    (s1_valid),
      .mag          (s1_mag),
      .clip         (s1_clip)
   );

   // Next state, envelope and hold counter; attack always takes priority.
   always_comb begin
      st_d     = st_q;
      env_d    = env_q;
      hold_d   = hold_q;
      att_step = (s1_mag - env_q) >> ATTACK_SHIFT;
      if (att_step == '0) att_step = EW'(1);
      rel_step = env_q >> RELEASE_SHIFT;
      if (rel_step == '0) rel_step = EW'(1);

      if (s1_valid) begin
         if (s1_mag > env_q) begin
            st_d  = ENV_ATTACK;
            env_d = env_q + att_step;
         end else begin
            case (st_q)
               ENV_ATTACK: begin
                  st_d   = ENV_HOLD;
                  hold_d = 16'(HOLD_SAMPLES);
               end
               ENV_HOLD: begin
                  if (hold_q == '0) st_d = ENV_RELEASE;
                  else              hold_d = hold_q - 16'd1;
               end
               ENV_RELEASE: begin
                  env_d = (env_q > rel_step) ? (env_q - rel_step) : '0;
                  if (env_d == '0) st_d = ENV_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   // State, envelope and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q            <= ENV_IDLE;
         env_q           <= '0;
         hold_q          <= '0;
         amplitude       <= '0;
         amplitude_valid <= 1'b0;
         clip            <= 1'b0;
      end else begin
         st_q            <= st_d;
         env_q           <= env_d;
         hold_q          <= hold_d;
         amplitude_valid <= s1_valid;
         if (s1_valid) begin
            amplitude <= env_d[DATA_BITS-2 -: AMPLITUDE_BITS];
            clip      <= s1_clip;
         end
      end
   end

   assign state = st_q;

endmodule

// File: tb/tb_envelope_follower.sv
module tb_envelope_follower;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] din = 12'h800;

   logic [7:0]  amp [3];
   logic        av  [3];
   logic        clp [3];
   logic [1:0]  st  [3];

   always #5 clk = ~clk;

   envelope_follower #(.HOLD_SAMPLES(256), .ATTACK_SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .din(din),
      .amplitude(amp[0]), .amplitude_valid(av[0]), .clip(clp[0]), .state(st[0]));
   envelope_follower #(.HOLD_SAMPLES(4), .ATTACK_SHIFT(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .din(din),
      .amplitude(amp[1]), .amplitude_valid(av[1]), .clip(clp[1]), .state(st[1]));
   envelope_follower #(.HOLD_SAMPLES(4), .ATTACK_SHIFT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .din(din),
      .amplitude(amp[2]), .amplitude_valid(av[2]), .clip(clp[2]), .state(st[2]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int hold_len [3] = '{256, 4, 4};
   int att_sh   [3] = '{0, 0, 2};
   int rel_sh = 4;

   int m_env [3], m_st [3], m_hold [3], e_amp [3];
   bit e_v, e_clip, pend_v, pend_clip;
   int pend_mag;

   function automatic int model_mag(input int d);
      int s = d - 2048;
      if (s < 0) s = -s;
      if (s > 2047) s = 2047;
      return s;
   endfunction

   function automatic int model_att(input int env, input int mag, input int sh);
      int step = (mag - env) / (1 << sh);
      if (step < 1) step = 1;
      return env + step;
   endfunction

   function automatic int model_rel(input int env, input int sh);
      int step = env / (1 << sh);
      if (step < 1) step = 1;
      return (env > step) ? env - step : 0;
   endfunction

   // States: 0 idle, 1 attack, 2 hold, 3 release.
   function automatic void model_apply(input int k, input int mag);
      if (mag > m_env[k]) begin
         m_env[k] = model_att(m_env[k], mag, att_sh[k]);
         m_st[k]  = 1;
      end else if (m_st[k] == 1) begin
         m_st[k]   = 2;
         m_hold[k] = hold_len[k];
      end else if (m_st[k] == 2) begin
         if (m_hold[k] == 0) m_st[k] = 3;
         else m_hold[k] = m_hold[k] - 1;
      end else if (m_st[k] == 3) begin
         m_env[k] = model_rel(m_env[k], rel_sh);
         if (m_env[k] == 0) m_st[k] = 0;
      end
   endfunction

   // Samples accepted on one edge land in the model on the next edge,
   // so the model's outputs line up with the DUT's two-cycle latency.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            m_env[k] = 0; m_st[k] = 0; m_hold[k] = 0; e_amp[k] = 0;
         end
         e_v = 0; e_clip = 0; pend_v = 0; pend_mag = 0; pend_clip = 0;
      end else begin
         e_v = pend_v;
         if (pend_v) begin
            e_clip = pend_clip;
            for (int k = 0; k < 3; k++) begin
               model_apply(k, pend_mag);
               e_amp[k] = m_env[k] / 8;
            end
         end
         pend_v    = sample_valid;
         pend_mag  = model_mag(int'(din));
         pend_clip = (din == 12'h000) || (din == 12'hFFF);
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            check($sformatf("valid%0d", k), int'(av[k]), int'(e_v));
            check($sformatf("amp%0d", k), int'(amp[k]), e_amp[k]);
            check($sformatf("state%0d", k), int'(st[k]), m_st[k]);
            if (e_v) check($sformatf("clip%0d", k), int'(clp[k]), int'(e_clip));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [11:0] seq_a [10] = '{12'hC00, 12'h800, 12'h800, 12'h800, 12'h800,
                               12'h800, 12'h800, 12'h800, 12'hDDC, 12'h800};
   int exp1_amp [10] = '{128, 128, 128, 128, 128, 128, 128, 120, 187, 187};
   int exp1_st  [10] = '{1, 2, 2, 2, 2, 2, 3, 3, 1, 2};
   logic [11:0] seq_c [3] = '{12'h000, 12'hFFF, 12'h801};
   int expc_clip [3] = '{1, 1, 0};

   initial begin
      // Reset held while samples are offered.
      repeat (4) begin
         @(negedge clk);
         check("rst_valid", int'(av[0]), 0);
         check("rst_amp", int'(amp[0]), 0);
         check("rst_state", int'(st[1]), 0);
         sample_valid = 1'b1;
         din = 12'($urandom_range(0, 4095));
      end
      @(negedge clk);
      sample_valid = 1'b0;
      din = 12'h800;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_silent", int'(av[0]), 0);
      end

      // Instant attack, hold, release, re-attack.
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         if (t >= 2) begin
            check($sformatf("seqA_valid[%0d]", t - 2), int'(av[1]), 1);
            check($sformatf("seqA_amp[%0d]", t - 2), int'(amp[1]), exp1_amp[t-2]);
            check($sformatf("seqA_state[%0d]", t - 2), int'(st[1]), exp1_st[t-2]);
            if (t == 2) begin
               check("attack_amp", int'(amp[0]), 128);
               check("attack_clip", int'(clp[0]), 0);
               check("attack_state", int'(st[0]), 1);
            end
         end
         if (t < 10) begin
            sample_valid = 1'b1;
            din = seq_a[t];
         end else begin
            sample_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("valid_one_cycle", int'(av[0]), 0);
      check("amp_holds", int'(amp[1]), 187);

      // Full-scale clip on both extremes.
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         if (t >= 2) begin
            check($sformatf("clip_amp[%0d]", t - 2), int'(amp[0]), 255);
            check($sformatf("clip_flag[%0d]", t - 2), int'(clp[0]), expc_clip[t-2]);
         end
         if (t < 3) begin
            sample_valid = 1'b1;
            din = seq_c[t];
         end else begin
            sample_valid = 1'b0;
         end
      end

      // Gapped silence decays the short-hold instances to idle.
      repeat (400) begin
         @(negedge clk);
         sample_valid = ($urandom_range(0, 3) != 0);
         din = 12'h800;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("decay_state1", int'(st[1]), 0);
      check("decay_amp1", int'(amp[1]), 0);
      check("decay_state2", int'(st[2]), 0);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_stays_state", int'(st[1]), 0);
      check("idle_stays_amp", int'(amp[1]), 0);

      // Randomized traffic with gaps and occasional mid-run resets.
      repeat (4000) begin
         @(negedge clk);
         if (rst_n == 1'b0) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
         end
         begin
            int r;
            r = $urandom_range(0, 99);
            sample_valid = ($urandom_range(0, 4) != 0);
            if (r < 40)      din = 12'h800;
            else if (r < 60) din = 12'(2048 + $urandom_range(0, 6) - 3);
            else if (r < 90) din = 12'($urandom_range(0, 4095));
            else             din = ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000;
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Pin the model to hand-computed values.
      check("pin_mag_000", model_mag(0), 2047);
      check("pin_mag_fff", model_mag(4095), 2047);
      check("pin_mag_c00", model_mag(12'hC00), 1024);
      check("pin_rel_1024", model_rel(1024, 4), 960);
      check("pin_rel_5", model_rel(5, 4), 4);
      check("pin_rel_1", model_rel(1, 4), 0);
      check("pin_att_sh0", model_att(960, 1500, 0), 1500);
      check("pin_att_sh2", model_att(960, 1500, 2), 1095);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/envelope_follower.md
# envelope_follower

Measures the amplitude of an offset-binary audio sample stream and produces an `AMPLITUDE_BITS`-wide envelope value. Attack, hold and release are configurable. This is the detection side of the amplitude modulator. Its `amplitude` output uses the same scale the modulator's amplitude input consumes (0 = silent, all-ones = full scale). Typical uses are side-chain ducking, compressors and envelope-driven effects in the synth voice path.

## Interface
- `DATA_BITS`, 12: sample width, offset-binary (midscale `2**(DATA_BITS-1)` = silence).
- `AMPLITUDE_BITS`, 8: output envelope width; must be ≤ `DATA_BITS-1`.
- `ATTACK_SHIFT`, 0: attack smoothing. 0 = instantaneous peak capture.
- `RELEASE_SHIFT`, 4: release decay rate, applied per processed sample.
- `HOLD_SAMPLES`, 256: number of samples the peak is held before release starts. 16-bit counter.
- `clk`  in  1: sole clock. All state updates on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `sample_valid`  in  1: qualifies `din`. May be high every cycle.
- `din`  in  DATA_BITS: offset-binary input sample.
- `amplitude`  out  AMPLITUDE_BITS: envelope, `env[DATA_BITS-2 -: AMPLITUDE_BITS]`.
- `amplitude_valid`  out  1: one-cycle pulse when `amplitude` reflects a new sample.
- `clip`  out  1: registered alongside `amplitude_valid`. High when that sample was at full scale (`din` all-zeros or all-ones).
- `state`  out  2: current FSM state, for debug.

## Operation
- **Stage 1, on `sample_valid`:**
  - `s = din ^ 2**(DATA_BITS-1)`, taken as signed.
  - `mag = |s|`, `DATA_BITS-1` bits unsigned. `s = -2**(DATA_BITS-1)` saturates to `2**(DATA_BITS-1)-1`.
  - The clip flag is computed here.
- **Stage 2: envelope register `env`, `DATA_BITS-1` bits unsigned.**
  - **Attack (`mag > env`):** `env += max(1, (mag-env) >> ATTACK_SHIFT)`. Never exceeds `mag`.
  - **Release step:** `env -= max(1, env >> RELEASE_SHIFT)`. Clamps at 0.
- **FSM states:** IDLE=0, ATTACK=1, HOLD=2, RELEASE=3. Evaluated once per stage-2 sample.
  - Any state, `mag > env`: go to ATTACK and apply an attack step.
  - ATTACK, `mag ≤ env`: go to HOLD, load `hold_cnt = HOLD_SAMPLES`. `env` unchanged.
  - HOLD, `mag ≤ env`: if `hold_cnt == 0`, go to RELEASE (`env` unchanged this sample); otherwise decrement `hold_cnt`.
  - RELEASE, `mag ≤ env`: apply a release step. Go to IDLE when the result is 0.
  - IDLE, `mag == 0`: stay; `env` stays 0.
- **Attack priority:** attack always wins. A new peak during HOLD or RELEASE re-enters ATTACK. `hold_cnt` is reloaded when HOLD is next entered.
- **Input gaps:** no `sample_valid` means no state, `env` or counter change. Hold and release are counted in samples, not cycles.

## Timing
- Latency is 2 cycles. `sample_valid` at cycle n gives `amplitude`, `clip` and `amplitude_valid` registered at the n+2 edge.
- Full throughput: one sample per cycle, back-to-back, with no stall and no dropped sample.
- `amplitude` holds its value between `amplitude_valid` pulses.
- **Reset values:** `amplitude=0`, `amplitude_valid=0`, `clip=0`, `state=IDLE`, `env=0`, `hold_cnt=0`, stage-1 valid cleared.
- **Reset mid-operation:** all in-flight samples are discarded. The first sample after deassertion appears 2 cycles after its `sample_valid`.

## Structure
- Shared synth package holds:
  - the FSM state encoding (`ENV_IDLE`, `ENV_ATTACK`, `ENV_HOLD`, `ENV_RELEASE`);
  - the offset-binary midscale constant, shared with the amplitude modulator.
- One natural sub-module: `offset_to_magnitude`. It does the stage-1 register: offset-binary conversion, absolute value with saturation, and clip detect.
- FSM and envelope arithmetic live in the top module.

## Test plan
All scenarios use default parameters unless stated.
- **Reset:** hold `rst_n=0` while driving samples. All outputs stay 0 and `state=IDLE`. After release, output stays silent until the first valid sample plus 2 cycles.
- **Instant attack:** single sample `din=12'hC00` (+1024) at cycle n. At n+2: `amplitude=128`, `amplitude_valid=1` for one cycle, `clip=0`, `state=ATTACK`.
- **Full-scale clip:** `din=12'h000` gives `amplitude=255` and `clip=1`. `din=12'hFFF` gives `amplitude=255` (env 2047) and `clip=1`.
- **Hold then release:**
  - Setup: `HOLD_SAMPLES=4`. Peak 1024, then zeros (`12'h800`) every cycle.
  - Zero samples 1–6: `amplitude=128`.
  - Sample 1 enters HOLD; samples 2–5 count down; sample 6 enters RELEASE.
  - Sample 7: `env=960`, `amplitude=120`.
- **Decay to idle:** `env=5` in RELEASE with zero input. Env steps by 1 per sample: 4,3,2,1,0. `state=IDLE` after the 5th sample. A further gapped `sample_valid` causes no change.
- **Re-attack during release:** at `env=960`, sample +1500 (`12'hDDC`) gives `env=1500`, `amplitude=187`, `state=ATTACK`. Then:
  - Next zero sample enters HOLD with `hold_cnt` reloaded.
  - Repeat with `ATTACK_SHIFT=2`: the first step is `env=960+135=1095`.
